// File: rtl/instr_fetch_if.sv
// Fetch/decode stage bus: memory read port, index-stage link,
// execute handshake, PC control inputs and fault reporting.
interface instr_fetch_if;
    logic        start;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [30:0] mem_rdata;
    logic [12:0] ix_in;
    logic [2:0]  ix_index;
    logic [11:0] ix_m;
    logic        inst_valid;
    logic        inst_ready;
    logic [11:0] m_out;
    logic [5:0]  f_out;
    logic [5:0]  c_out;
    logic [11:0] pc;
    logic        jump_en;
    logic [11:0] jump_addr;
    logic        halt_req;
    logic        fault;
    logic [2:0]  fault_code;

    modport master (
        input  start, mem_ack, mem_rdata, ix_m, inst_ready,
        input  jump_en, jump_addr, halt_req,
        output mem_rd, mem_addr, ix_in, ix_index, inst_valid,
        output m_out, f_out, c_out, pc, fault, fault_code
    );

    modport slave (
        output start, mem_ack, mem_rdata, ix_m, inst_ready,
        output jump_en, jump_addr, halt_req,
        input  mem_rd, mem_addr, ix_in, ix_index, inst_valid,
        input  m_out, f_out, c_out, pc, fault, fault_code
    );
endinterface

// File: rtl/instr_fetch.sv
// MIX fetch/decode stage: fetch at pc, split word, get M from index stage,
// issue M/F/C to execute, sequence pc. FETCH_TIMEOUT_EN adds an ack timeout.
module instr_fetch #(
    parameter int MEM_WORDS = 4000,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, FAULT
    } state_t;

    localparam logic [12:0] MW = 13'(MEM_WORDS);

    state_t      state, state_nx;
    logic [30:0] ir;
    logic [11:0] pc_r;
    logic [11:0] m_r;
    logic [2:0]  code_r;
    logic [2:0]  code_nx;
    logic        ir_ld, m_ld, pc_ld, code_ld;
    logic [12:0] tgt;
    logic        tmo;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ?
                        $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tcnt;

    // count FETCH cycles that pass without an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (state != FETCH)
            tcnt <= '0;
        else if (!bus.mem_ack)
            tcnt <= tcnt + 1'b1;
    end

    assign tmo = (state == FETCH) && !bus.mem_ack &&
                 (tcnt == TW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    assign tgt = bus.jump_en ? {1'b0, bus.jump_addr}
                             : {1'b0, pc_r} + 13'd1;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and datapath load strobes
    always_comb begin
        state_nx = state;
        ir_ld    = 1'b0;
        m_ld     = 1'b0;
        pc_ld    = 1'b0;
        code_ld  = 1'b0;
        code_nx  = 3'd0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = FETCH;
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    ir_ld    = 1'b1;
                    state_nx = DECODE;
                end else if (tmo) begin
                    code_ld  = 1'b1;
                    code_nx  = 3'd4;
                    state_nx = FAULT;
                end
            end
            DECODE: begin
                if (ir[17:12] > 6'd6) begin
                    code_ld  = 1'b1;
                    code_nx  = 3'd1;
                    state_nx = FAULT;
                end else if ({1'b0, bus.ix_m} >= MW) begin
                    code_ld  = 1'b1;
                    code_nx  = 3'd2;
                    state_nx = FAULT;
                end else begin
                    m_ld     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.inst_ready) begin
                    if (tgt >= MW) begin
                        code_ld  = 1'b1;
                        code_nx  = 3'd3;
                        state_nx = FAULT;
                    end else begin
                        pc_ld    = 1'b1;
                        state_nx = bus.halt_req ? IDLE : FETCH;
                    end
                end
            end
            FAULT: begin
                state_nx = FAULT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // instruction, M, pc and fault code registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir     <= '0;
            m_r    <= '0;
            pc_r   <= '0;
            code_r <= '0;
        end else begin
            if (ir_ld)
                ir <= bus.mem_rdata;
            if (m_ld)
                m_r <= bus.ix_m;
            if (pc_ld)
                pc_r <= tgt[11:0];
            if (code_ld)
                code_r <= code_nx;
        end
    end

    assign bus.mem_rd     = (state == FETCH);
    assign bus.mem_addr   = pc_r;
    assign bus.ix_in      = {ir[30], ir[29:18]};
    assign bus.ix_index   = ir[14:12];
    assign bus.inst_valid = (state == ISSUE);
    assign bus.m_out      = m_r;
    assign bus.f_out      = ir[11:6];
    assign bus.c_out      = ir[5:0];
    assign bus.pc         = pc_r;
    assign bus.fault      = (state == FAULT);
    assign bus.fault_code = code_r;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reset, vector table, directed corner sequences,
// random program run against a word-level fetch/issue model.
module tb_instr_fetch;
    localparam int MW = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.MEM_WORDS(MW), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [30:0] mem [0:4095];
    int ireg [0:7];
    int ack_mode = 2;
    int wcnt = 0;

    typedef struct {
        bit s;
        int aa;
        int i;
        int f;
        int c;
        int rv;
        int exp_code;
        int exp_m;
    } vec_t;

    function automatic logic [30:0] mk(bit s, int aa, int i, int f, int c);
        return {s, 12'(aa), 6'(i), 6'(f), 6'(c)};
    endfunction

    // index stage: signed AA plus index register, out of range -> marker
    function automatic int ixm(logic [12:0] in, int rv);
        int v;
        v = int'(in[11:0]);
        if (in[12]) v = -v;
        v += rv;
        if (v < 0 || v > 4095) return MW;
        return v;
    endfunction

    assign bus.ix_m = 12'(ixm(bus.ix_in, ireg[bus.ix_index]));

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // memory responder
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            case (ack_mode)
                0: if (bus.mem_rd) begin
                    if (wcnt == 0) begin
                        bus.mem_ack = 1'b1;
                        wcnt = $urandom_range(0, 2);
                    end else wcnt--;
                end
                2: bus.mem_ack = bus.mem_rd;
                3: bus.mem_ack = 1'b1;
                default: ;
            endcase
            bus.mem_rdata = mem[bus.mem_addr];
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.inst_ready = 1'b0;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        bus.halt_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic hs(bit je, int ja, bit hr);
        bus.inst_ready = 1'b1;
        bus.jump_en = je;
        bus.jump_addr = 12'(ja);
        bus.halt_req = hr;
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b0;
        bus.jump_en = 1'b0;
        bus.halt_req = 1'b0;
    endtask

    task automatic wait_iss(output bit got, output bit saw_v, output int lfa);
        got = 0;
        saw_v = 0;
        lfa = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.mem_rd) lfa = int'(bus.mem_addr);
            if (bus.inst_valid) begin
                saw_v = 1; got = 1; break;
            end
            if (bus.fault) begin
                got = 1; break;
            end
        end
        if (!got) chk("wait_bound", 0, 1);
    endtask

    initial begin
        vec_t tbl [9];
        bit got, sv;
        int lf, n, pc_m;
        logic [30:0] w;

        tbl[0] = '{0, 2000, 1, 5, 8, 5, 0, 2005};
        tbl[1] = '{0, 3999, 0, 1, 2, 0, 0, 3999};
        tbl[2] = '{0, 10, 7, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 10, 9, 0, 0, 0, 1, 0};
        tbl[4] = '{0, 3990, 2, 0, 0, 10, 2, 0};
        tbl[5] = '{1, 5, 3, 0, 0, 3, 2, 0};
        tbl[6] = '{1, 5, 4, 63, 63, 20, 0, 15};
        tbl[7] = '{0, 4095, 0, 0, 0, 0, 2, 0};
        tbl[8] = '{0, 0, 6, 7, 9, 3999, 0, 3999};

        for (int a = 0; a < 4096; a++) mem[a] = '0;
        for (int k = 0; k < 8; k++) ireg[k] = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.inst_ready = 1'b0;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        bus.halt_req = 1'b0;

        @(negedge clk);
        chk("rst_mem_rd", int'(bus.mem_rd), 0);
        chk("rst_valid", int'(bus.inst_valid), 0);
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_m", int'(bus.m_out), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_code", int'(bus.fault_code), 0);
        chk("rst_ix_in", int'(bus.ix_in), 0);
        rst = 1'b0;

        // vector table: one instruction from reset each
        for (int v = 0; v < 9; v++) begin
            do_reset();
            ack_mode = 0;
            for (int k = 0; k < 8; k++) ireg[k] = 0;
            ireg[tbl[v].i & 7] = tbl[v].rv;
            mem[0] = mk(tbl[v].s, tbl[v].aa, tbl[v].i, tbl[v].f, tbl[v].c);
            pulse_start();
            wait_iss(got, sv, lf);
            chk($sformatf("tbl%0d_code", v),
                bus.fault ? int'(bus.fault_code) : 0, tbl[v].exp_code);
            chk($sformatf("tbl%0d_valid", v), int'(sv),
                (tbl[v].exp_code == 0) ? 1 : 0);
            if (tbl[v].exp_code == 0) begin
                chk($sformatf("tbl%0d_m", v), int'(bus.m_out), tbl[v].exp_m);
                chk($sformatf("tbl%0d_f", v), int'(bus.f_out), tbl[v].f);
                chk($sformatf("tbl%0d_c", v), int'(bus.c_out), tbl[v].c);
                chk($sformatf("tbl%0d_pc", v), int'(bus.pc), 0);
            end
        end

        // latency, stall, jump to 3999 then run off the end
        do_reset();
        ack_mode = 2;
        for (int k = 0; k < 8; k++) ireg[k] = 0;
        ireg[1] = 5;
        mem[0] = mk(0, 2000, 1, 5, 8);
        mem[1] = mk(0, 10, 0, 0, 1);
        mem[3999] = mk(0, 5, 0, 2, 3);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(negedge clk);
        chk("lat_t0_rd", int'(bus.mem_rd), 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("lat_t1_rd", int'(bus.mem_rd), 1);
        chk("lat_t1_addr", int'(bus.mem_addr), 0);
        @(negedge clk);
        chk("lat_t2_valid", int'(bus.inst_valid), 0);
        @(negedge clk);
        chk("lat_t3_valid", int'(bus.inst_valid), 1);
        chk("lat_m", int'(bus.m_out), 2005);
        chk("lat_f", int'(bus.f_out), 5);
        chk("lat_c", int'(bus.c_out), 8);
        chk("lat_pc", int'(bus.pc), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_hold", int'(bus.inst_valid && bus.m_out == 12'd2005 &&
                bus.f_out == 6'd5 && bus.c_out == 6'd8 && bus.pc == 12'd0), 1);
        end
        hs(0, 0, 0);
        @(negedge clk);
        chk("seq_rd", int'(bus.mem_rd), 1);
        chk("seq_addr", int'(bus.mem_addr), 1);
        chk("seq_pc", int'(bus.pc), 1);
        wait_iss(got, sv, lf);
        chk("seq_m", int'(bus.m_out), 10);
        hs(1, 3999, 0);
        wait_iss(got, sv, lf);
        chk("jmp_fetch", lf, 3999);
        chk("jmp_valid", int'(sv), 1);
        chk("jmp_pc", int'(bus.pc), 3999);
        hs(0, 0, 0);
        @(negedge clk);
        chk("end_fault", int'(bus.fault), 1);
        chk("end_code", int'(bus.fault_code), 3);
        chk("end_pc", int'(bus.pc), 3999);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("fault_hold", int'(bus.fault && !bus.mem_rd && !bus.inst_valid), 1);

        // reset in the middle of a fetch, ack arriving afterwards
        do_reset();
        ack_mode = 2;
        mem[0] = mk(0, 1, 0, 0, 0);
        pulse_start();
        wait_iss(got, sv, lf);
        hs(1, 100, 0);
        ack_mode = 1;
        @(negedge clk);
        chk("mid_rd", int'(bus.mem_rd), 1);
        chk("mid_addr", int'(bus.mem_addr), 100);
        rst = 1'b1;
        #1;
        chk("mid_rd_drop", int'(bus.mem_rd), 0);
        chk("mid_pc", int'(bus.pc), 0);
        ack_mode = 3;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_ack_idle",
            int'(bus.mem_rd || bus.inst_valid || bus.fault), 0);
        chk("late_ack_pc", int'(bus.pc), 0);

        // ack never arrives
        do_reset();
        ack_mode = 1;
        pulse_start();
        n = 0;
        while (bus.mem_rd && n < 100) begin
            n++;
            @(negedge clk);
        end
`ifdef FETCH_TIMEOUT_EN
        chk("tmo_cycles", n, 16);
        chk("tmo_code", int'(bus.fault_code), 4);
`else
        chk("wait_forever", n, 100);
        chk("wait_no_fault", int'(bus.fault), 0);
`endif

        // random program against the word-level model
        for (int a = 0; a < MW; a++) begin
            int ii, aa;
            ii = ($urandom_range(0, 15) == 0) ? $urandom_range(7, 63)
                                              : $urandom_range(0, 6);
            aa = ($urandom_range(0, 9) == 0) ? $urandom_range(3980, 4095)
                                             : $urandom_range(0, 3999);
            mem[a] = mk($urandom_range(0, 7) == 0, aa, ii,
                        $urandom_range(0, 63), $urandom_range(0, 63));
        end
        for (int k = 1; k < 7; k++) ireg[k] = $urandom_range(0, 40) - 20;
        do_reset();
        ack_mode = 0;
        pc_m = 0;
        pulse_start();
        for (int t = 0; t < 300; t++) begin
            int ic, mm, ec, nxt, r, ja;
            bit je, hr;
            w = mem[pc_m];
            ic = int'(w[17:12]);
            mm = ixm({w[30], w[29:18]}, ireg[w[14:12]]);
            ec = (ic > 6) ? 1 : ((mm >= MW) ? 2 : 0);
            wait_iss(got, sv, lf);
            chk("rnd_code", bus.fault ? int'(bus.fault_code) : 0, ec);
            if (ec == 0 && sv) begin
                chk("rnd_pc", int'(bus.pc), pc_m);
                chk("rnd_m", int'(bus.m_out), mm);
                chk("rnd_fc", int'({bus.f_out, bus.c_out}), int'(w[11:0]));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                r = $urandom_range(0, 99);
                je = (r < 30);
                ja = (r < 5) ? $urandom_range(3990, 4095)
                             : $urandom_range(0, 3999);
                hr = ($urandom_range(0, 19) == 0);
                nxt = je ? ja : pc_m + 1;
                hs(je, ja, hr);
                if (nxt >= MW) begin
                    @(negedge clk);
                    chk("rnd_end_code", int'(bus.fault_code), 3);
                    chk("rnd_end_pc", int'(bus.pc), pc_m);
                    do_reset();
                    pc_m = 0;
                    pulse_start();
                end else begin
                    pc_m = nxt;
                    if (hr) begin
                        repeat (2) @(negedge clk);
                        chk("rnd_halt", int'(bus.mem_rd || bus.inst_valid), 0);
                        pulse_start();
                    end
                end
            end else begin
                do_reset();
                pc_m = 0;
                pulse_start();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
